// File: rtl/pc_sequencer_if.sv
// Decoder-to-PC-sequencer bus: command handshake, data byte, vector select and PC/address results.
// The sequencer sits on the slave modport and the instruction decoder on the master modport.
interface pc_sequencer_if;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  db_in;
    logic [1:0]  vec_sel;
    logic [15:0] pc_out;
    logic [15:0] addr_out;
    logic        page_cross;
    logic        busy;

    modport master (
        output cmd,
        output cmd_valid,
        output db_in,
        output vec_sel,
        input  cmd_ready,
        input  pc_out,
        input  addr_out,
        input  page_cross,
        input  busy
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        input  db_in,
        input  vec_sel,
        output cmd_ready,
        output pc_out,
        output addr_out,
        output page_cross,
        output busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// 65C02-style PC sequencer: INC/LOAD in 1 cycle, page-crossing BRANCH in 2, VECTOR fetch in 3.
// Ready only in IDLE; commands offered while busy are dropped, not queued.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] VEC_BASE = 16'hFFFA
) (
    input  logic          fclk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BR_FIX = 2'd1;
    localparam logic [1:0] ST_VEC_LO = 2'd2;
    localparam logic [1:0] ST_VEC_HI = 2'd3;

    localparam logic [2:0] CMD_INC     = 3'd1;
    localparam logic [2:0] CMD_LOAD_LO = 3'd2;
    localparam logic [2:0] CMD_LOAD_HI = 3'd3;
    localparam logic [2:0] CMD_BRANCH  = 3'd4;
    localparam logic [2:0] CMD_VECTOR  = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  tmp_lo_q, tmp_lo_d;
    logic [7:0]  br_hi_q, br_hi_d;
    logic [15:0] vec_q, vec_d;
    logic        page_cross_q, page_cross_d;

    logic        accept;
    logic [15:0] br_off;
    logic [15:0] br_target;
    logic        br_same_page;
    logic [15:0] vec_addr;

    assign accept       = bus.cmd_valid && (state_q == ST_IDLE);
    assign br_off       = {{8{bus.db_in[7]}}, bus.db_in};
    assign br_target    = pc_q + br_off;
    assign br_same_page = (br_target[15:8] == pc_q[15:8]);

    always_comb begin
        vec_addr = VEC_BASE + 16'd4;
        case (bus.vec_sel)
            2'd0:    vec_addr = VEC_BASE;
            2'd1:    vec_addr = VEC_BASE + 16'd2;
            default: vec_addr = VEC_BASE + 16'd4;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tmp_lo_d = tmp_lo_q;
        br_hi_d  = br_hi_q;
        vec_d    = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_INC:     pc_d = pc_q + 16'd1;
                        CMD_LOAD_LO: tmp_lo_d = bus.db_in;
                        CMD_LOAD_HI: pc_d = {bus.db_in, tmp_lo_q};
                        CMD_BRANCH: begin
                            if (br_same_page) begin
                                pc_d = br_target;
                            end else begin
                                // Low byte lands now; the high byte is fixed up a cycle later.
                                pc_d    = {pc_q[15:8], br_target[7:0]};
                                br_hi_d = br_target[15:8];
                                state_d = ST_BR_FIX;
                            end
                        end
                        CMD_VECTOR: begin
                            vec_d   = vec_addr;
                            state_d = ST_VEC_LO;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BR_FIX: begin
                pc_d    = {br_hi_q, pc_q[7:0]};
                state_d = ST_IDLE;
            end
            ST_VEC_LO: begin
                tmp_lo_d = bus.db_in;
                state_d  = ST_VEC_HI;
            end
            ST_VEC_HI: begin
                pc_d    = {bus.db_in, tmp_lo_q};
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered decode keeps page_cross free of combinational glitches.
    assign page_cross_d = (state_d == ST_BR_FIX);

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            tmp_lo_q     <= 8'h00;
            br_hi_q      <= 8'h00;
            vec_q        <= 16'h0000;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tmp_lo_q     <= tmp_lo_d;
            br_hi_q      <= br_hi_d;
            vec_q        <= vec_d;
            page_cross_q <= page_cross_d;
        end
    end

    always_comb begin
        bus.addr_out = pc_q;
        case (state_q)
            ST_VEC_LO: bus.addr_out = vec_q;
            ST_VEC_HI: bus.addr_out = vec_q + 16'd1;
            default:   bus.addr_out = pc_q;
        endcase
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.pc_out     = pc_q;
    assign bus.page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed 65C02 PC-sequencer scenarios followed by random command traffic against a byte-level reference model.
module tb_pc_sequencer;

    localparam logic [15:0] TB_RESET_PC = 16'h0000;
    localparam logic [15:0] TB_VEC_BASE = 16'hFFFA;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_INC = 3'd1;
    localparam logic [2:0] C_LLO = 3'd2;
    localparam logic [2:0] C_LHI = 3'd3;
    localparam logic [2:0] C_BR  = 3'd4;
    localparam logic [2:0] C_VEC = 3'd5;

    logic fclk = 1'b0;
    logic rst  = 1'b1;

    pc_sequencer_if u_if ();

    pc_sequencer #(
        .RESET_PC (TB_RESET_PC),
        .VEC_BASE (TB_VEC_BASE)
    ) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (u_if.slave)
    );

    always #5 fclk = ~fclk;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural PC and the pending low byte.
    logic [15:0] m_pc  = TB_RESET_PC;
    logic [7:0]  m_tmp = 8'h00;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pc"}, u_if.pc_out, m_pc);
        chk({tag, "_addr"}, u_if.addr_out, m_pc);
        chk_b({tag, "_rdy"}, u_if.cmd_ready, 1'b1);
        chk_b({tag, "_busy"}, u_if.busy, 1'b0);
        chk_b({tag, "_pcx"}, u_if.page_cross, 1'b0);
    endtask

    // While busy, keep offering a valid INC: it must be ignored.
    task automatic drive_junk();
        u_if.cmd       = C_INC;
        u_if.cmd_valid = 1'b1;
    endtask

    // Offer one command in IDLE, then walk any multi-cycle sequence, checking every cycle.
    task automatic do_cmd(input logic vld, input logic [2:0] c, input logic [7:0] d,
                          input logic [1:0] s, input logic [7:0] vlo, input logic [7:0] vhi);
        int off, tgt;
        logic [15:0] mid, v;
        @(negedge fclk);
        u_if.cmd       = c;
        u_if.cmd_valid = vld;
        u_if.db_in     = d;
        u_if.vec_sel   = s;
        chk_idle("pre");
        @(posedge fclk);
        #1;
        if (!vld) return;
        case (c)
            C_INC: m_pc = m_pc + 16'd1;
            C_LLO: m_tmp = d;
            C_LHI: m_pc = {d, m_tmp};
            C_BR: begin
                off = (d > 8'd127) ? int'(d) - 256 : int'(d);
                tgt = (int'(m_pc) + off + 65536) % 65536;
                if ((tgt / 256) == (int'(m_pc) / 256)) begin
                    m_pc = 16'(tgt);
                end else begin
                    mid = 16'((int'(m_pc) / 256) * 256 + tgt % 256);
                    drive_junk();
                    @(negedge fclk);
                    chk("fix_pc", u_if.pc_out, mid);
                    chk("fix_addr", u_if.addr_out, mid);
                    chk_b("fix_pcx", u_if.page_cross, 1'b1);
                    chk_b("fix_rdy", u_if.cmd_ready, 1'b0);
                    chk_b("fix_busy", u_if.busy, 1'b1);
                    @(posedge fclk);
                    #1;
                    m_pc = 16'(tgt);
                end
            end
            C_VEC: begin
                v = TB_VEC_BASE + 16'(2 * ((s == 2'd0) ? 0 : (s == 2'd1) ? 1 : 2));
                drive_junk();
                @(negedge fclk);
                u_if.db_in = vlo;
                chk("vlo_addr", u_if.addr_out, v);
                chk("vlo_pc", u_if.pc_out, m_pc);
                chk_b("vlo_rdy", u_if.cmd_ready, 1'b0);
                chk_b("vlo_pcx", u_if.page_cross, 1'b0);
                @(posedge fclk);
                #1;
                @(negedge fclk);
                u_if.db_in = vhi;
                chk("vhi_addr", u_if.addr_out, v + 16'd1);
                chk("vhi_pc", u_if.pc_out, m_pc);
                chk_b("vhi_busy", u_if.busy, 1'b1);
                @(posedge fclk);
                #1;
                m_tmp = vlo;
                m_pc  = {vhi, vlo};
            end
            default: ;
        endcase
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] val);
        do_cmd(1'b1, C_LLO, val[7:0], 2'd0, 8'h00, 8'h00);
        do_cmd(1'b1, C_LHI, val[15:8], 2'd0, 8'h00, 8'h00);
    endtask

    initial begin
        u_if.cmd       = C_NOP;
        u_if.cmd_valid = 1'b0;
        u_if.db_in     = 8'h00;
        u_if.vec_sel   = 2'd0;

        // 1: reset state, then RESET vector fetch.
        repeat (2) @(negedge fclk);
        chk("rst_pc", u_if.pc_out, 16'h0000);
        chk_b("rst_rdy", u_if.cmd_ready, 1'b1);
        chk_b("rst_pcx", u_if.page_cross, 1'b0);
        rst = 1'b0;
        do_cmd(1'b1, C_VEC, 8'h00, 2'd1, 8'h34, 8'h12);
        chk("t1_pc", u_if.pc_out, 16'h1234);
        chk_b("t1_rdy", u_if.cmd_ready, 1'b1);

        // 2: same-page branch, then forward page-crossing branch.
        load_pc(16'h12FE);
        do_cmd(1'b1, C_BR, 8'h01, 2'd0, 8'h00, 8'h00);
        chk("t2a_pc", u_if.pc_out, 16'h12FF);
        chk_b("t2a_pcx", u_if.page_cross, 1'b0);
        do_cmd(1'b1, C_BR, 8'h7F, 2'd0, 8'h00, 8'h00);
        chk("t2b_pc", u_if.pc_out, 16'h137E);

        // 3: backward page-crossing branch, INC wrap.
        load_pc(16'h1300);
        do_cmd(1'b1, C_BR, 8'hFE, 2'd0, 8'h00, 8'h00);
        chk("t3_pc", u_if.pc_out, 16'h12FE);
        load_pc(16'hFFFF);
        do_cmd(1'b1, C_INC, 8'h00, 2'd0, 8'h00, 8'h00);
        chk("t3_wrap", u_if.pc_out, 16'h0000);

        // 4: two-byte load.
        load_pc(16'hABCD);
        chk("t4_pc", u_if.pc_out, 16'hABCD);

        // 5: reset in VEC_HI of an NMI fetch.
        @(negedge fclk);
        u_if.cmd = C_VEC; u_if.cmd_valid = 1'b1; u_if.vec_sel = 2'd0;
        @(posedge fclk);
        #1;
        drive_junk();
        @(negedge fclk);
        u_if.db_in = 8'h77;
        chk("t5_vlo", u_if.addr_out, 16'hFFFA);
        @(posedge fclk);
        #1;
        @(negedge fclk);
        u_if.db_in = 8'h66;
        chk("t5_vhi", u_if.addr_out, 16'hFFFB);
        rst = 1'b1;
        #1;
        chk("t5_pc", u_if.pc_out, 16'h0000);
        chk_b("t5_rdy", u_if.cmd_ready, 1'b1);
        chk_b("t5_pcx", u_if.page_cross, 1'b0);
        u_if.cmd_valid = 1'b0;
        @(posedge fclk);
        #2;
        rst   = 1'b0;
        m_pc  = TB_RESET_PC;
        m_tmp = 8'h00;
        do_cmd(1'b1, C_LHI, 8'h55, 2'd0, 8'h00, 8'h00);
        chk("t5_tmp", u_if.pc_out, 16'h5500);

        // 6: back-to-back INC from 00FD with no stalls.
        load_pc(16'h00FD);
        for (int i = 0; i < 5; i++) begin
            do_cmd(1'b1, C_INC, 8'h00, 2'd0, 8'h00, 8'h00);
            chk("t6_pc", u_if.pc_out, 16'(16'h00FE + i));
        end

        // Random traffic, including reserved opcodes and idle cycles.
        for (int n = 0; n < 400; n++) begin
            do_cmd(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                   2'($urandom), 8'($urandom), 8'($urandom));
        end
        @(negedge fclk);
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the 16-bit program counter formed by the low-byte register and the PCH high-byte register.
- Accepts one command per cycle from the instruction decoder: increment, two-byte load from the data bus, relative branch with page-cross fix-up, and interrupt/reset vector fetch.
- Drives the PC value and the address bus selection during vector fetches.
- Owns all PCL/PCH update timing, so that high-byte carries/borrows take the extra cycle the 65C02 requires.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset before the reset vector fetch.
- VEC_BASE, 16'hFFFA, NMI vector address. RESET = VEC_BASE+2, IRQ/BRK = VEC_BASE+4.

Ports:
- fclk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd  in  3  0 NOP, 1 INC, 2 LOAD_LO, 3 LOAD_HI, 4 BRANCH, 5 VECTOR, 6-7 reserved (treated as NOP)
- cmd_valid  in  1  cmd is presented this cycle
- cmd_ready  out  1  sequencer accepts cmd this cycle
- db_in  in  8  data bus: branch offset, load byte, or vector byte
- vec_sel  in  2  0 NMI, 1 RESET, 2 IRQ/BRK, 3 same as IRQ/BRK; sampled when VECTOR is accepted
- pc_out  out  16  current PC
- addr_out  out  16  address bus request: vector address in VEC_LO/VEC_HI, else pc_out
- page_cross  out  1  high during the branch fix-up cycle
- busy  out  1  = ~cmd_ready

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, tmp_lo=8'h00, state=IDLE, vec latch=0, page_cross=0, cmd_ready=1. rst during BR_FIX or VEC_* aborts the operation; the PC is not partially updated beyond what is already registered.
- States: IDLE, BR_FIX, VEC_LO, VEC_HI. cmd_ready=1 only in IDLE.
- A command is accepted on the rising edge when cmd_valid & cmd_ready. Commands presented while busy are ignored and are not queued.
- INC: pc <= pc+1 at the accept edge. Wraps FFFF -> 0000. Single cycle, no extra penalty.
- LOAD_LO: tmp_lo <= db_in. PC is unchanged.
- LOAD_HI: pc <= {db_in, tmp_lo}. A LOAD_HI without a preceding LOAD_LO uses the current tmp_lo.
- BRANCH: off = sign-extended db_in; target = pc+off (16-bit, wraps).
  - If target[15:8] == pc[15:8]: pc <= target, stay IDLE (1 cycle).
  - Else: pc[7:0] <= target[7:0] at the accept edge, save target[15:8], go to BR_FIX.
  - In BR_FIX: page_cross=1, addr_out shows the intermediate (wrong-page) PC. At the next edge pc[15:8] <= saved high byte, return to IDLE.
  - Total 2 cycles.
- VECTOR: latch vector address V per vec_sel, go to VEC_LO.
  - VEC_LO: addr_out=V, tmp_lo <= db_in at the edge, go to VEC_HI.
  - VEC_HI: addr_out=V+1, pc <= {db_in, tmp_lo} at the edge, go to IDLE.
  - New PC is visible on pc_out 3 edges after acceptance.
- NOP/reserved: no state change.
- page_cross is a registered state decode and is glitch-free. busy is combinational from state only, with no path from cmd.
- All PC arithmetic is modulo 2^16. The branch boundary is judged only by the high-byte comparison.

Test Plan:
1. Reset -> pc_out=0000, cmd_ready=1, page_cross=0. VECTOR vec_sel=1 with db_in=34 in VEC_LO and 12 in VEC_HI -> addr_out FFFC then FFFD, pc_out=1234 after 3 edges, busy high for exactly 2 cycles.
2. pc=12FE, BRANCH db_in=01 -> pc=12FF in 1 cycle, page_cross never asserted. Then BRANCH db_in=7F -> pc=137E via intermediate 127E, page_cross=1 for one cycle.
3. pc=1300, BRANCH db_in=FE (-2) -> intermediate 13FE, then 12FE, page_cross 1 cycle. pc=FFFF, INC -> 0000.
4. LOAD_LO db=CD, LOAD_HI db=AB -> pc_out=ABCD. INC issued during BR_FIX -> ignored (pc unchanged by it, cmd_ready=0 in that cycle).
5. Assert rst in VEC_HI of an NMI fetch -> pc_out=0000 immediately (async), state IDLE, cmd_ready=1 next cycle, no load of the partial vector.
6. Back-to-back INC on 5 consecutive cycles from 00FD -> 00FE, 00FF, 0100, 0101, 0102, with no stall cycles.
